pio_poll_ctrl: RTL

Sequencer that periodically polls the 32-bit PIO input slave (`in_port` behind a registered Avalon-MM read mux) and delivers captured samples on a valid/ready stream through a small FIFO. It owns the PIO slave's `address` input outright, so the CPU reads buffered samples instead of busy-polling the port. An optional change-only filter suppresses repeated values. Sits between the PIO input core and the sample consumer (DMA or CPU-side stream adapter).

---
 rtl/pio_poll_pkg.sv | 17 +
 rtl/pio_poll_fifo.sv | 61 ++++++
 rtl/pio_poll_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO polling sequencer.
package pio_poll_pkg;

  localparam int unsigned TS_W  = 16;
  localparam int unsigned OVF_W = 8;

  localparam logic [1:0]       PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0]       PIO_ADDR_PARK = 2'd1;
  localparam logic [OVF_W-1:0] OVF_MAX       = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CAPTURE = 2'd2
  } poll_state_t;

endpackage

// File: rtl/pio_poll_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible on rdata whenever not empty.
// A pop on the same cycle as a push into a full FIFO frees the slot first.
module pio_poll_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/pio_poll_ctrl.sv
// Periodic poller for the PIO input slave, buffering samples into a show-ahead FIFO.
// Optional PIO_POLL_TIMESTAMP_EN attaches a 16-bit launch timestamp to each sample.
module pio_poll_ctrl
  import pio_poll_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PERIOD_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [PERIOD_W-1:0]           cfg_period,
  input  logic                          cfg_change_only,
  output logic [1:0]                    pio_address,
  input  logic [DATA_W-1:0]             pio_readdata,
  output logic [DATA_W-1:0]             sample_data,
  output logic                          sample_valid,
  input  logic                          sample_ready,
`ifdef PIO_POLL_TIMESTAMP_EN
  output logic [TS_W-1:0]               sample_ts,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [OVF_W-1:0]              overflow_cnt
);

`ifdef PIO_POLL_TIMESTAMP_EN
  localparam int unsigned FIFO_W = DATA_W + TS_W;
`else
  localparam int unsigned FIFO_W = DATA_W;
`endif

  poll_state_t         state;
  poll_state_t         state_nxt;
  logic [1:0]          address_nxt;
  logic                launch;
  logic [PERIOD_W-1:0] pcnt;
  logic                due;
  logic [DATA_W-1:0]   last;
  logic                last_vld;
  logic                capture;
  logic                push_req;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FIFO_W-1:0]   fifo_wdata;
  logic [FIFO_W-1:0]   fifo_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pio_address <= PIO_ADDR_PARK;
    end else begin
      state       <= state_nxt;
      pio_address <= address_nxt;
    end
  end

  // Address is derived from the next state so it is registered alongside it.
  always_comb begin
    state_nxt   = state;
    address_nxt = PIO_ADDR_PARK;
    launch      = 1'b0;
    case (state)
      IDLE: begin
        if (due && (cfg_period != '0)) begin
          launch    = 1'b1;
          state_nxt = ADDR;
        end
      end
      ADDR:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt != IDLE) address_nxt = PIO_ADDR_DATA;
  end

  // Period counter: due latches once the count hits 0 and survives busy cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      due  <= 1'b1;
    end else if (launch) begin
      pcnt <= cfg_period - PERIOD_W'(1);
      due  <= 1'b0;
    end else begin
      if (pcnt != '0) pcnt <= pcnt - PERIOD_W'(1);
      if (pcnt <= PERIOD_W'(1)) due <= 1'b1;
    end
  end

  assign capture  = (state == CAPTURE);
  assign push_req = capture && (!cfg_change_only || !last_vld || (pio_readdata != last));
  assign pop      = sample_ready && !fifo_empty;
  assign drop     = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last     <= '0;
      last_vld <= 1'b0;
    end else if (capture) begin
      last     <= pio_readdata;
      last_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_cnt <= '0;
    end else if (drop && (overflow_cnt != OVF_MAX)) begin
      overflow_cnt <= overflow_cnt + OVF_W'(1);
    end
  end

`ifdef PIO_POLL_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_addr;

  // Free-running cycle counter, sampled in the ADDR cycle of each poll.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt  <= '0;
      ts_addr <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      if (state == ADDR) ts_addr <= ts_cnt;
    end
  end

  assign fifo_wdata = {ts_addr, pio_readdata};
  assign sample_ts  = fifo_rdata[FIFO_W-1 -: TS_W];
`else
  assign fifo_wdata = pio_readdata;
`endif

  assign sample_data  = fifo_rdata[DATA_W-1:0];
  assign sample_valid = !fifo_empty;

  pio_poll_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .wdata   (fifo_wdata),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule
